fir_128_mdc_engine: RTL and testbench

//  Time-multiplexed FIR datapath for the fir_128_mdc HWPE. It sits between the streamer source (x stream) and
//  the streamer sink (y stream), inside fir_128_mdc_top. Each accepted sample costs T MAC cycles, one per

---
 rtl/fir_128_mdc_pkg.sv | 26 ++
 rtl/fir_128_mdc_shift_sat.sv | 35 +++
 rtl/fir_128_mdc_engine.sv | 149 ++++++++++++++
 tb/tb_fir_128_mdc_engine.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_128_mdc_pkg.sv
`timescale 1ns/1ps
// Shared widths, FSM state encoding and latched per-sample configuration
// for the fir_128_mdc time-multiplexed FIR engine.
package fir_128_mdc_package;

    localparam int FIR_N_TAPS  = 128;
    localparam int FIR_DATA_W  = 16;
    localparam int FIR_COEFF_W = 16;
    localparam int FIR_ACC_W   = 40;
    localparam int FIR_OUT_W   = 32;
    localparam int FIR_SHIFT_W = 6;
    localparam int FIR_ADDR_W  = $clog2(FIR_N_TAPS);
    localparam int FIR_TAPS_W  = FIR_ADDR_W + 1;

    typedef enum logic [1:0] {
        FIR_IDLE = 2'd0,
        FIR_MAC  = 2'd1,
        FIR_OUT  = 2'd2
    } fir_state_t;

    typedef struct packed {
        logic [FIR_TAPS_W-1:0]  taps;
        logic [FIR_SHIFT_W-1:0] shift;
    } fir_cfg_t;

endpackage

// File: rtl/fir_128_mdc_shift_sat.sv
`timescale 1ns/1ps
// Arithmetic right shift of the accumulator followed by clamping to the
// signed output range. Truncating, no rounding. Purely combinational.
module fir_128_mdc_shift_sat
    import fir_128_mdc_package::*;
#(
    parameter int ACC_W   = FIR_ACC_W,
    parameter int OUT_W   = FIR_OUT_W,
    parameter int SHIFT_W = FIR_SHIFT_W
) (
    input  logic signed [ACC_W-1:0]   acc_i,
    input  logic        [SHIFT_W-1:0] shift_i,
    output logic        [OUT_W-1:0]   y_o
);

    logic signed [ACC_W-1:0] shifted;
    logic                    pos_ovf;
    logic                    neg_ovf;

    assign shifted = acc_i >>> shift_i;

    // In range only when every bit above the output sign bit copies the sign.
    assign pos_ovf = !shifted[ACC_W-1] &&  (|shifted[ACC_W-2:OUT_W-1]);
    assign neg_ovf =  shifted[ACC_W-1] && !(&shifted[ACC_W-2:OUT_W-1]);

    always_comb begin
        y_o = shifted[OUT_W-1:0];
        if (pos_ovf) begin
            y_o = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (neg_ovf) begin
            y_o = {1'b1, {(OUT_W-1){1'b0}}};
        end
    end

endmodule

// File: rtl/fir_128_mdc_engine.sv
`timescale 1ns/1ps
// Time-multiplexed FIR engine: accepts one sample, runs one MAC per active tap,
// then presents the shifted/saturated result on a valid/ready output.
module fir_128_mdc_engine
    import fir_128_mdc_package::*;
#(
    parameter int N_TAPS  = FIR_N_TAPS,
    parameter int DATA_W  = FIR_DATA_W,
    parameter int COEFF_W = FIR_COEFF_W,
    parameter int ACC_W   = FIR_ACC_W,
    parameter int OUT_W   = FIR_OUT_W
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        clear_i,
    input  logic [$clog2(N_TAPS):0]     taps_i,
    input  logic [5:0]                  shift_i,
    input  logic                        coeff_we_i,
    input  logic [$clog2(N_TAPS)-1:0]   coeff_addr_i,
    input  logic [COEFF_W-1:0]          coeff_data_i,
    input  logic                        x_valid_i,
    output logic                        x_ready_o,
    input  logic [DATA_W-1:0]           x_data_i,
    output logic                        y_valid_o,
    input  logic                        y_ready_i,
    output logic [OUT_W-1:0]            y_data_o,
    output logic                        busy_o,
    output logic [31:0]                 out_cnt_o
);

    localparam int ADDR_W = $clog2(N_TAPS);
    localparam int TAPS_W = ADDR_W + 1;
    localparam int PROD_W = DATA_W + COEFF_W;

    fir_state_t                 state_reg, state_next;
    fir_cfg_t                   cfg_reg;
    logic signed [ACC_W-1:0]    acc_reg, acc_next;
    logic [ADDR_W-1:0]          k_reg, wr_ptr_reg, rd_idx;
    logic [OUT_W-1:0]           y_data_reg, y_sat;
    logic [31:0]                out_cnt_reg;
    logic [TAPS_W-1:0]          taps_eff;

    logic signed [DATA_W-1:0]   dline_reg [N_TAPS];
    logic signed [COEFF_W-1:0]  coeff_reg [N_TAPS];
    logic [N_TAPS-1:0]          dline_wr_sel, coeff_wr_sel;

    logic signed [DATA_W-1:0]   mac_x;
    logic signed [COEFF_W-1:0]  mac_c;
    logic signed [PROD_W-1:0]   prod;
    logic                       x_fire, y_fire, mac_done, coeff_wr_ok;

    assign x_fire      = (state_reg == FIR_IDLE) && x_valid_i && !clear_i;
    assign y_fire      = (state_reg == FIR_OUT) && y_ready_i;
    assign coeff_wr_ok = coeff_we_i && (state_reg == FIR_IDLE) && !clear_i;
    assign taps_eff    = (taps_i == '0 || taps_i > TAPS_W'(N_TAPS)) ? TAPS_W'(N_TAPS) : taps_i;
    assign mac_done    = (state_reg == FIR_MAC) && ({1'b0, k_reg} == cfg_reg.taps - TAPS_W'(1));

    // Tap k looks k samples back from the newest one; the index wraps naturally.
    assign rd_idx   = wr_ptr_reg - k_reg;
    assign mac_x    = dline_reg[rd_idx];
    assign mac_c    = coeff_reg[k_reg];
    assign prod     = PROD_W'(mac_x) * PROD_W'(mac_c);
    assign acc_next = acc_reg + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

    for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_wr_sel
        assign dline_wr_sel[gi] = x_fire && (wr_ptr_reg == ADDR_W'(gi));
        assign coeff_wr_sel[gi] = coeff_wr_ok && (coeff_addr_i == ADDR_W'(gi));
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < N_TAPS; i++) begin
            if (rst_i || clear_i) begin
                dline_reg[i] <= '0;
            end else if (dline_wr_sel[i]) begin
                dline_reg[i] <= x_data_i;
            end
        end
    end

    // Coefficients survive a soft clear; only a hard reset wipes them.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < N_TAPS; i++) begin
            if (rst_i) begin
                coeff_reg[i] <= '0;
            end else if (coeff_wr_sel[i]) begin
                coeff_reg[i] <= coeff_data_i;
            end
        end
    end

    fir_128_mdc_shift_sat #(
        .ACC_W   (ACC_W),
        .OUT_W   (OUT_W),
        .SHIFT_W (FIR_SHIFT_W)
    ) u_shift_sat (
        .acc_i   (acc_next),
        .shift_i (cfg_reg.shift),
        .y_o     (y_sat)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FIR_IDLE: if (x_valid_i) state_next = FIR_MAC;
            FIR_MAC:  if (mac_done)  state_next = FIR_OUT;
            FIR_OUT:  if (y_ready_i) state_next = FIR_IDLE;
            default:                 state_next = FIR_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_reg   <= FIR_IDLE;
            cfg_reg     <= '0;
            acc_reg     <= '0;
            k_reg       <= '0;
            wr_ptr_reg  <= '0;
            y_data_reg  <= '0;
            out_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (x_fire) begin
                cfg_reg.taps  <= taps_eff;
                cfg_reg.shift <= shift_i;
                acc_reg       <= '0;
                k_reg         <= '0;
            end
            if (state_reg == FIR_MAC) begin
                acc_reg <= acc_next;
                k_reg   <= k_reg + ADDR_W'(1);
            end
            // Result is captured on the last MAC so it is stable for the whole OUT phase.
            if (mac_done) begin
                wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
                y_data_reg <= y_sat;
            end
            if (y_fire) begin
                out_cnt_reg <= out_cnt_reg + 32'd1;
            end
        end
    end

    assign x_ready_o = (state_reg == FIR_IDLE);
    assign y_valid_o = (state_reg == FIR_OUT);
    assign busy_o    = (state_reg == FIR_MAC) || (state_reg == FIR_OUT);
    assign y_data_o  = y_data_reg;
    assign out_cnt_o = out_cnt_reg;

endmodule

// File: tb/tb_fir_128_mdc_engine.sv
`timescale 1ns/1ps
// Directed bench for fir_128_mdc_engine: impulse, latency/shift, backpressure,
// saturation, mid-MAC clear and long wrap run against a reference model.
module tb_fir_128_mdc_engine;

    logic        clk = 1'b0;
    logic        rst, clear, coeff_we, x_valid, y_ready;
    logic [7:0]  taps;
    logic [5:0]  shift;
    logic [6:0]  coeff_addr;
    logic [15:0] coeff_data, x_data;
    logic        x_ready, y_valid, busy;
    logic [31:0] y_data, out_cnt;

    int n_vec = 0;
    int n_err = 0;

    shortint m_coeff [128];
    shortint m_hist  [128];
    int      m_ptr;

    always #5 clk = ~clk;

    fir_128_mdc_engine dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .clear_i      (clear),
        .taps_i       (taps),
        .shift_i      (shift),
        .coeff_we_i   (coeff_we),
        .coeff_addr_i (coeff_addr),
        .coeff_data_i (coeff_data),
        .x_valid_i    (x_valid),
        .x_ready_o    (x_ready),
        .x_data_i     (x_data),
        .y_valid_o    (y_valid),
        .y_ready_i    (y_ready),
        .y_data_o     (y_data),
        .busy_o       (busy),
        .out_cnt_o    (out_cnt)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coeff(input int k, input logic [15:0] v);
        coeff_we   = 1'b1;
        coeff_addr = 7'(k);
        coeff_data = v;
        tick();
        coeff_we   = 1'b0;
        m_coeff[k] = shortint'(v);
    endtask

    function automatic logic [31:0] model_step(input logic [15:0] x, input int t, input int sh);
        longint acc = 0;
        int     te  = (t == 0 || t > 128) ? 128 : t;
        m_hist[m_ptr] = shortint'(x);
        for (int k = 0; k < te; k++)
            acc += longint'(m_coeff[k]) * longint'(m_hist[(m_ptr - k + 128) % 128]);
        m_ptr = (m_ptr + 1) % 128;
        acc = acc >>> sh;
        if (acc > 64'sd2147483647)  return 32'h7fffffff;
        if (acc < -64'sd2147483648) return 32'h80000000;
        return acc[31:0];
    endfunction

    // Sends one sample; returns the first valid y and cycles from handshake to y_valid.
    task automatic push(input logic [15:0] x, input bit poke, output logic [31:0] y, output int lat);
        int w = 0;
        x_valid = 1'b1;
        x_data  = x;
        while (!x_ready && w < 1000) begin
            tick();
            w++;
        end
        if (!x_ready) check_val("x_ready_wait", x_ready, 1);
        tick();
        x_valid = 1'b0;
        lat = 1;
        if (poke) begin
            coeff_we   = 1'b1;
            coeff_addr = x[6:0];
            coeff_data = 16'h5a5a;
            taps       = 8'd3;
            shift      = 6'd0;
            tick();
            coeff_we = 1'b0;
            lat++;
        end
        while (!y_valid && lat < 1000) begin
            tick();
            lat++;
        end
        if (!y_valid) check_val("y_valid_wait", y_valid, 1);
        y = y_data;
        $display("txn x=%04h y=%08h lat=%0d cnt=%0d", x, y, lat, out_cnt);
        if (y_ready) tick();
    endtask

    task automatic run(input string tag, input logic [15:0] x, input bit poke);
        logic [31:0] exp_y, y;
        int          lat;
        logic [7:0]  t_save = taps;
        logic [5:0]  s_save = shift;
        exp_y = model_step(x, int'(taps), int'(shift));
        push(x, poke, y, lat);
        taps  = t_save;
        shift = s_save;
        check_val(tag, y, exp_y);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] y, cnt0, held;
        int          lat;
        int          imp_exp [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 0};

        rst = 1'b1; clear = 1'b0; coeff_we = 1'b0; x_valid = 1'b0; y_ready = 1'b1;
        taps = 8'd0; shift = 6'd0; coeff_addr = '0; coeff_data = '0; x_data = '0;
        for (int i = 0; i < 128; i++) begin
            m_coeff[i] = 0;
            m_hist[i]  = 0;
        end
        m_ptr = 0;
        repeat (3) tick();
        check_val("rst_x_ready", x_ready, 1);
        check_val("rst_y_valid", y_valid, 0);
        check_val("rst_y_data", y_data, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_out_cnt", out_cnt, 0);
        rst = 1'b0;
        tick();

        // Impulse response through 8 taps
        for (int k = 0; k < 8; k++) write_coeff(k, 16'(k + 1));
        taps = 8'd8; shift = 6'd0;
        for (int i = 0; i < 9; i++) begin
            void'(model_step(16'((i == 0) ? 1 : 0), 8, 0));
            push(16'((i == 0) ? 1 : 0), 1'b0, y, lat);
            check_val($sformatf("impulse_%0d", i), y, 32'(imp_exp[i]));
        end
        check_val("impulse_cnt", out_cnt, 9);

        // Shift and latency: 4*3 >>> 2 = 3, y_valid at handshake + T + 1
        for (int k = 0; k < 4; k++) write_coeff(k, 16'd4);
        taps = 8'd4; shift = 6'd2;
        void'(model_step(16'd3, 4, 2));
        push(16'd3, 1'b0, y, lat);
        check_val("shift_y", y, 3);
        check_val("shift_lat", lat, 5);

        // Backpressure with a dropped coefficient write during OUT
        y_ready = 1'b0;
        cnt0 = out_cnt;
        void'(model_step(16'd5, 4, 2));
        push(16'd5, 1'b0, y, lat);
        check_val("bp_y", y, 8);
        held = y_data;
        coeff_we = 1'b1; coeff_addr = 7'd0; coeff_data = 16'd100;
        for (int i = 0; i < 10; i++) begin
            tick();
            coeff_we = 1'b0;
            check_val("bp_hold", y_data, held);
            check_val("bp_valid", y_valid, 1);
            check_val("bp_x_ready", x_ready, 0);
        end
        check_val("bp_cnt_wait", out_cnt, cnt0);
        y_ready = 1'b1;
        tick();
        check_val("bp_cnt_done", out_cnt, cnt0 + 1);
        check_val("bp_valid_drop", y_valid, 0);
        void'(model_step(16'd1, 4, 2));
        push(16'd1, 1'b0, y, lat);
        check_val("bp_coeff_kept", y, 9);

        // Saturation with full 128-tap history
        for (int k = 0; k < 128; k++) write_coeff(k, 16'h7fff);
        taps = 8'd0; shift = 6'd0;
        for (int i = 0; i < 128; i++) run("sat_pos_model", 16'h7fff, 1'b0);
        void'(model_step(16'h7fff, 0, 0));
        push(16'h7fff, 1'b0, y, lat);
        check_val("sat_pos", y, 32'h7fffffff);
        for (int k = 0; k < 128; k++) write_coeff(k, 16'h8000);
        void'(model_step(16'h7fff, 0, 0));
        push(16'h7fff, 1'b0, y, lat);
        check_val("sat_neg", y, 32'h80000000);
        shift = 6'd8;
        void'(model_step(16'h7fff, 0, 8));
        push(16'h7fff, 1'b0, y, lat);
        check_val("sat_shift8", y, 32'he0004000);
        shift = 6'd63;
        void'(model_step(16'h7fff, 0, 63));
        push(16'h7fff, 1'b0, y, lat);
        check_val("sat_shift63", y, 32'hffffffff);

        // Clear in the middle of a 128-tap MAC
        for (int k = 0; k < 128; k++) write_coeff(k, 16'(k + 1));
        taps = 8'd0; shift = 6'd0;
        for (int i = 0; i < 7; i++) run("pre_clear", 16'd5, 1'b0);
        cnt0 = out_cnt;
        x_valid = 1'b1; x_data = 16'd9;
        tick();
        x_valid = 1'b0;
        repeat (50) tick();
        check_val("mid_busy", busy, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_val("clr_x_ready", x_ready, 1);
        check_val("clr_busy", busy, 0);
        check_val("clr_y_valid", y_valid, 0);
        check_val("clr_y_data", y_data, 0);
        check_val("clr_out_cnt", out_cnt, 0);
        for (int i = 0; i < 128; i++) m_hist[i] = 0;
        m_ptr = 0;
        for (int i = 0; i < 3; i++) begin
            void'(model_step(16'((i == 0) ? 1 : 0), 0, 0));
            push(16'((i == 0) ? 1 : 0), 1'b0, y, lat);
            check_val($sformatf("clr_impulse_%0d", i), y, 32'(i + 1));
        end

        // Long run across delay-line wrap with ignored writes and config changes mid-MAC
        for (int k = 0; k < 128; k++) write_coeff(k, 16'((k * 37) % 200 - 100));
        taps = 8'd128; shift = 6'd3;
        for (int i = 0; i < 300; i++) run("wrap", 16'((i * 1103 + 7) % 2001 - 1000), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
